// File: rtl/unified_mem_arbiter.sv
// Arbitrates one shared memory port between the instruction-fetch and data ports.
// The data port has priority, one transaction is outstanding at a time, and a stalled access is aborted after MAX_WAIT cycles.
module unified_mem_arbiter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_ready,
    input  logic             dm_read,
    input  logic             dm_write,
    input  logic [WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0] dm_wdata,
    output logic [WIDTH-1:0] dm_rdata,
    output logic             dm_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             stall,
    output logic             err
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

    logic             mem_req_nxt, mem_we_nxt, if_ready_nxt, dm_ready_nxt, err_nxt;
    logic [WIDTH-1:0] mem_addr_nxt, mem_wdata_nxt, if_rdata_nxt, dm_rdata_nxt;

    logic dm_pend_c, busy_c, done_c, timeout_c;

    assign dm_pend_c = dm_read | dm_write;
    assign busy_c    = (state != IDLE);
    // A late ack on the saturation cycle still wins over the timeout.
    assign done_c    = busy_c & mem_ack;
    assign timeout_c = busy_c & ~mem_ack & (wait_cnt == CNT_W'(MAX_WAIT));

    assign stall = (dm_pend_c & ~dm_ready) | (if_req & ~if_ready);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dm_pend_c)   state_nxt = DATA;
                else if (if_req) state_nxt = FETCH;
            end
            DATA, FETCH: begin
                if (done_c || timeout_c) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs
    always_comb begin
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        if_rdata_nxt  = if_rdata;
        dm_rdata_nxt  = dm_rdata;
        if_ready_nxt  = 1'b0;
        dm_ready_nxt  = 1'b0;
        err_nxt       = err;
        wait_cnt_nxt  = wait_cnt;
        case (state)
            IDLE: begin
                if (dm_pend_c) begin
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = dm_write;
                    mem_addr_nxt  = dm_addr;
                    mem_wdata_nxt = dm_write ? dm_wdata : '0;
                    wait_cnt_nxt  = '0;
                end else if (if_req) begin
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = if_addr;
                    mem_wdata_nxt = '0;
                    wait_cnt_nxt  = '0;
                end
            end
            DATA, FETCH: begin
                if (done_c) begin
                    mem_req_nxt = 1'b0;
                    if (state == DATA) begin
                        dm_ready_nxt = 1'b1;
                        if (!mem_we) dm_rdata_nxt = mem_rdata;
                    end else begin
                        if_ready_nxt = 1'b1;
                        if_rdata_nxt = mem_rdata;
                    end
                end else if (timeout_c) begin
                    mem_req_nxt = 1'b0;
                    err_nxt     = 1'b1;
                    if (state == DATA) begin
                        dm_ready_nxt = 1'b1;
                        dm_rdata_nxt = '0;
                    end else begin
                        if_ready_nxt = 1'b1;
                        if_rdata_nxt = '0;
                    end
                end else if (wait_cnt != CNT_W'(MAX_WAIT)) begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            err       <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            if_rdata  <= if_rdata_nxt;
            dm_rdata  <= dm_rdata_nxt;
            if_ready  <= if_ready_nxt;
            dm_ready  <= dm_ready_nxt;
            err       <= err_nxt;
            wait_cnt  <= wait_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: a transaction-level model predicts grants, latency, read data, timeouts and err.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_unified_mem_arbiter;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned MAX_WAIT = 15;
    localparam int          NEVER    = 1000;

    logic             clk = 1'b0;
    logic             rst;
    logic             if_req, dm_read, dm_write, mem_ack;
    logic [WIDTH-1:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [WIDTH-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic             if_ready, dm_ready, mem_req, mem_we, stall, err;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] exp_if_rdata, exp_dm_rdata;
    logic             exp_err;

    unified_mem_arbiter #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_stall(input bit dm_rdy, input bit if_rdy);
        #1;
        check("stall", 32'(stall), 32'(((dm_read | dm_write) & ~dm_rdy) | (if_req & ~if_rdy)));
    endtask

    task automatic chk_idle_state();
        check("idle_mem_req", 32'(mem_req), 32'(1'b0));
        check("idle_dm_ready", 32'(dm_ready), 32'(1'b0));
        check("idle_if_ready", 32'(if_ready), 32'(1'b0));
        check("idle_dm_rdata", dm_rdata, exp_dm_rdata);
        check("idle_if_rdata", if_rdata, exp_if_rdata);
        check("idle_err", 32'(err), 32'(exp_err));
    endtask

    task automatic chk_reset_vals();
        check("rst_mem_req", 32'(mem_req), 32'(1'b0));
        check("rst_mem_we", 32'(mem_we), 32'(1'b0));
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_if_ready", 32'(if_ready), 32'(1'b0));
        check("rst_dm_ready", 32'(dm_ready), 32'(1'b0));
        check("rst_if_rdata", if_rdata, '0);
        check("rst_dm_rdata", dm_rdata, '0);
        check("rst_err", 32'(err), 32'(1'b0));
    endtask

    // Idle cycles with optional stray acks, which must never produce a completion.
    task automatic idle_cycles(input int n, input bit force_ack);
        for (int k = 0; k < n; k++) begin
            mem_ack   = force_ack ? 1'b1 : 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            @(negedge clk);
            chk_idle_state();
        end
    endtask

    // One granted transaction: entered on the negedge before mem_req is due, left on the ready-pulse negedge.
    task automatic serve(input bit is_dm, input logic [WIDTH-1:0] addr, input bit we,
                         input logic [WIDTH-1:0] wd, input int d, input logic [WIDTH-1:0] rd_val,
                         input bit drop);
        bit acked;
        acked = 1'b0;
        @(negedge clk);
        for (int i = 0; i <= int'(MAX_WAIT); i++) begin
            check(is_dm ? "dm_mem_req" : "if_mem_req", 32'(mem_req), 32'(1'b1));
            check(is_dm ? "dm_mem_addr" : "if_mem_addr", mem_addr, addr);
            check(is_dm ? "dm_mem_we" : "if_mem_we", 32'(mem_we), 32'(we));
            if (we) check("mem_wdata", mem_wdata, wd);
            check("busy_dm_ready", 32'(dm_ready), 32'(1'b0));
            check("busy_if_ready", 32'(if_ready), 32'(1'b0));
            mem_ack   = (i == d);
            mem_rdata = (i == d) ? rd_val : $urandom;
            if (drop && i == 0) begin
                if (is_dm) begin dm_read = 1'b0; dm_write = 1'b0; end
                else if_req = 1'b0;
            end
            chk_stall(1'b0, 1'b0);
            @(negedge clk);
            if (i == d) begin
                acked = 1'b1;
                break;
            end
        end
        if (!acked) exp_err = 1'b1;
        if (is_dm) begin
            if (!acked) exp_dm_rdata = '0;
            else if (!we) exp_dm_rdata = rd_val;
        end else begin
            exp_if_rdata = acked ? rd_val : '0;
        end
        check("done_mem_req", 32'(mem_req), 32'(1'b0));
        check("done_dm_ready", 32'(dm_ready), 32'(is_dm));
        check("done_if_ready", 32'(if_ready), 32'(!is_dm));
        check("done_dm_rdata", dm_rdata, exp_dm_rdata);
        check("done_if_rdata", if_rdata, exp_if_rdata);
        check("done_err", 32'(err), 32'(exp_err));
        if (is_dm) begin dm_read = 1'b0; dm_write = 1'b0; end
        else if_req = 1'b0;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        chk_stall(is_dm, !is_dm);
    endtask

    // Raise the requested ports together and expect data first, then fetch one IDLE cycle later.
    task automatic scenario(input bit do_dm, input bit dr, input bit dw,
                            input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] dwd,
                            input int d_dm, input logic [WIDTH-1:0] rd_dm, input bit drop_dm,
                            input bit do_if, input logic [WIDTH-1:0] ia,
                            input int d_if, input logic [WIDTH-1:0] rd_if, input bit drop_if,
                            input bit stray_ack);
        dm_read   = do_dm & dr;
        dm_write  = do_dm & dw;
        dm_addr   = da;
        dm_wdata  = dwd;
        if_req    = do_if;
        if_addr   = ia;
        mem_ack   = stray_ack ? 1'b1 : 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        chk_stall(1'b0, 1'b0);
        if (do_dm) serve(1'b1, da, dw, dwd, d_dm, rd_dm, drop_dm);
        if (do_if) serve(1'b0, ia, 1'b0, '0, d_if, rd_if, drop_if);
        mem_ack = 1'b0;
        @(negedge clk);
        chk_idle_state();
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0; mem_ack = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        exp_if_rdata = '0; exp_dm_rdata = '0; exp_err = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b1;

        // Fetch granted on the first edge after release, ack two cycles after mem_req.
        scenario(1'b0, 1'b0, 1'b0, '0, '0, 0, '0, 1'b0,
                 1'b1, 32'h40, 2, 32'h8C01_0004, 1'b0, 1'b0);
        // Simultaneous fetch and data read: data first.
        scenario(1'b1, 1'b1, 1'b0, 32'h100, '0, 1, 32'h1234_5678, 1'b0,
                 1'b1, 32'h44, 0, 32'hCAFE_0001, 1'b0, 1'b0);
        // Write leaves dm_rdata alone.
        scenario(1'b1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3, 32'h5555_AAAA, 1'b0,
                 1'b0, '0, 0, '0, 1'b0, 1'b0);
        // Stray acks in IDLE, then read+write issues as a write.
        idle_cycles(3, 1'b1);
        scenario(1'b1, 1'b1, 1'b1, 32'h20, 32'h0BAD_F00D, 2, 32'h7777_7777, 1'b0,
                 1'b0, '0, 0, '0, 1'b0, 1'b1);
        // Ack on the saturation cycle completes normally, with request dropped mid-flight.
        scenario(1'b0, 1'b0, 1'b0, '0, '0, 0, '0, 1'b0,
                 1'b1, 32'h80, int'(MAX_WAIT), 32'h1357_9BDF, 1'b1, 1'b0);
        // No ack at all: timeout, zero data, sticky err.
        scenario(1'b1, 1'b1, 1'b0, 32'h200, '0, NEVER, '0, 1'b0,
                 1'b1, 32'h84, 1, 32'h2468_ACE0, 1'b0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            bit do_dm, do_if, dr, dw;
            int d_dm, d_if;
            do_dm = 1'($urandom_range(0, 1));
            do_if = 1'($urandom_range(0, 1));
            dr    = 1'($urandom_range(0, 1));
            dw    = ~dr | 1'($urandom_range(0, 1));
            d_dm  = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, MAX_WAIT));
            d_if  = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, MAX_WAIT));
            if (!do_dm && !do_if) idle_cycles(int'($urandom_range(1, 3)), 1'b0);
            else scenario(do_dm, dr, dw, $urandom, $urandom, d_dm, $urandom,
                          ($urandom_range(0, 3) == 0),
                          do_if, $urandom, d_if, $urandom, ($urandom_range(0, 3) == 0),
                          1'b0);
        end

        // Reset off-edge mid-fetch: everything clears at once and no ready follows.
        if_req  = 1'b1;
        if_addr = 32'h300;
        mem_ack = 1'b0;
        @(negedge clk);
        check("pre_rst_mem_req", 32'(mem_req), 32'(1'b1));
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_reset_vals();
        exp_if_rdata = '0; exp_dm_rdata = '0; exp_err = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(4, 1'b0);
        scenario(1'b1, 1'b1, 1'b0, 32'h400, '0, 4, 32'h0F0F_0F0F, 1'b0,
                 1'b1, 32'h404, 2, 32'hF0F0_F0F0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
